// File: rtl/hdmi_pix_feeder.sv
// rtl/hdmi_pix_feeder.sv - FIFO-buffered pixel feeder for hdmi_if with start-of-frame alignment
// Optional uf_cnt/rs_cnt statistics outputs: define HDMI_PIX_FEEDER_STATS_EN.
`ifndef CNT_HSYC_W
`define CNT_HSYC_W 12
`endif
`ifndef CNT_VSYC_W
`define CNT_VSYC_W 11
`endif

module hdmi_pix_feeder #(
  parameter int          FIFO_AW      = 6,
  parameter int          H_ACT        = 1280,
  parameter int          V_ACT        = 720,
  parameter int          V_BLANK_LINE = 0,
  parameter logic [23:0] FILL_RGB     = 24'h000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [23:0]            s_data,
  input  logic                   s_sof,
  input  logic [`CNT_HSYC_W-1:0] hcount,
  input  logic [`CNT_VSYC_W-1:0] vcount,
  input  logic                   dat_rdy,
  output logic [23:0]            dat_out,
  output logic                   locked,
`ifdef HDMI_PIX_FEEDER_STATS_EN
  output logic [15:0]            uf_cnt,
  output logic [15:0]            rs_cnt,
`endif
  output logic                   underflow
);

  localparam int FRAME_PIX = H_ACT * V_ACT;
  localparam int PW        = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam int DEPTH     = 1 << FIFO_AW;
  localparam int VW        = `CNT_VSYC_W;

  localparam logic [PW-1:0]      PIX_LAST   = PW'(FRAME_PIX - 1);
  localparam logic [PW-1:0]      PIX_FIRST  = PW'((FRAME_PIX > 1) ? 1 : 0);
  localparam logic [FIFO_AW:0]   FULL_OCC   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [VW-1:0]      V_ARM_LINE = VW'(V_BLANK_LINE);

  localparam logic [1:0] ST_SYNC   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_RESYNC = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    pix_cnt_q, pix_cnt_d;
  logic [23:0]      dat_out_q, dat_out_d;
  logic             underflow_q, underflow_d;
  logic             arm_q, arm_d;
  logic             rdy_en_q, rdy_en_d;
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic [24:0]      mem_q [DEPTH];

  logic [FIFO_AW:0] occ;
  logic             full, empty, flushing, push, pop;
  logic             head_sof, arm_set, uf_evt, rs_evt;
  logic [23:0]      head_rgb;

  // Horizontal position is not needed: pix_cnt alone defines frame position.
  logic unused_hcount;
  assign unused_hcount = ^hcount;

  assign occ      = wr_ptr_q - rd_ptr_q;
  assign full     = (occ == FULL_OCC);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign head_sof = mem_q[rd_ptr_q[FIFO_AW-1:0]][24];
  assign head_rgb = mem_q[rd_ptr_q[FIFO_AW-1:0]][23:0];
  assign flushing = (state_q != ST_RUN) && !empty && !head_sof;
  assign s_ready  = rdy_en_q && (!full || flushing);
  assign push     = s_valid && s_ready;
  assign arm_set  = (vcount == V_ARM_LINE) && !dat_rdy;

  assign dat_out   = dat_out_q;
  assign locked    = (state_q == ST_RUN);
  assign underflow = underflow_q;

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    dat_out_d   = dat_out_q;
    underflow_d = underflow_q;
    arm_d       = arm_q;
    rdy_en_d    = 1'b1;
    pop         = 1'b0;
    uf_evt      = 1'b0;
    rs_evt      = 1'b0;

    if (arm_set) begin
      arm_d = 1'b1;
    end else if (dat_rdy) begin
      arm_d = 1'b0;
    end

    if (state_q == ST_RUN) begin
      if (dat_rdy) begin
        if (empty) begin
          dat_out_d   = FILL_RGB;
          underflow_d = 1'b1;
          uf_evt      = 1'b1;
          rs_evt      = 1'b1;
          state_d     = ST_RESYNC;
          pix_cnt_d   = '0;
        end else if (head_sof && (pix_cnt_q != '0)) begin
          // Early sof stays at the head so the next frame can lock on it.
          dat_out_d = FILL_RGB;
          rs_evt    = 1'b1;
          state_d   = ST_RESYNC;
          pix_cnt_d = '0;
        end else if (!head_sof && (pix_cnt_q == '0)) begin
          pop       = 1'b1;
          dat_out_d = FILL_RGB;
          rs_evt    = 1'b1;
          state_d   = ST_RESYNC;
        end else begin
          pop       = 1'b1;
          dat_out_d = head_rgb;
          pix_cnt_d = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + PW'(1);
        end
      end
    end else begin
      pop = flushing;
      if (dat_rdy) begin
        dat_out_d = FILL_RGB;
      end
      if ((state_q == ST_SYNC) && dat_rdy && !empty && head_sof && arm_q) begin
        pop       = 1'b1;
        dat_out_d = head_rgb;
        pix_cnt_d = PIX_FIRST;
        state_d   = ST_RUN;
      end else if ((state_q != ST_SYNC) && arm_set) begin
        state_d   = ST_SYNC;
        pix_cnt_d = '0;
      end
    end

    wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {s_sof, s_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_SYNC;
      pix_cnt_q   <= '0;
      dat_out_q   <= FILL_RGB;
      underflow_q <= 1'b0;
      arm_q       <= 1'b0;
      rdy_en_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      dat_out_q   <= dat_out_d;
      underflow_q <= underflow_d;
      arm_q       <= arm_d;
      rdy_en_q    <= rdy_en_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

`ifdef HDMI_PIX_FEEDER_STATS_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;
  logic [15:0] rs_cnt_q, rs_cnt_d;

  always_comb begin
    uf_cnt_d = uf_cnt_q;
    rs_cnt_d = rs_cnt_q;
    if (uf_evt && (uf_cnt_q != 16'hFFFF)) begin
      uf_cnt_d = uf_cnt_q + 16'd1;
    end
    if (rs_evt && (rs_cnt_q != 16'hFFFF)) begin
      rs_cnt_d = rs_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uf_cnt_q <= '0;
      rs_cnt_q <= '0;
    end else begin
      uf_cnt_q <= uf_cnt_d;
      rs_cnt_q <= rs_cnt_d;
    end
  end

  assign uf_cnt = uf_cnt_q;
  assign rs_cnt = rs_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = uf_evt ^ rs_evt;
`endif

endmodule

// File: tb/tb_hdmi_pix_feeder.sv
// tb/tb_hdmi_pix_feeder.sv - self-checking bench for hdmi_pix_feeder against a queue-based frame model
`ifndef CNT_HSYC_W
`define CNT_HSYC_W 12
`endif
`ifndef CNT_VSYC_W
`define CNT_VSYC_W 11
`endif

module tb_hdmi_pix_feeder;

  localparam int          H_ACT    = 4;
  localparam int          V_ACT    = 2;
  localparam int          FIFO_AW  = 3;
  localparam int          DEPTH    = 8;
  localparam int          FRAME    = H_ACT * V_ACT;
  localparam int          V_BLANK  = 0;
  localparam logic [23:0] FILL     = 24'h0000FF;
  localparam int          HW       = `CNT_HSYC_W;
  localparam int          VW       = `CNT_VSYC_W;
  localparam int          MS_SYNC  = 0;
  localparam int          MS_RUN   = 1;
  localparam int          MS_RESYNC = 2;

  typedef struct packed {
    logic        sof;
    logic [23:0] rgb;
  } px_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [23:0]   s_data;
  logic          s_sof;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          dat_rdy;
  logic [23:0]   dat_out;
  logic          locked;
  logic          underflow;
`ifdef HDMI_PIX_FEEDER_STATS_EN
  logic [15:0]   uf_cnt;
  logic [15:0]   rs_cnt;
`endif

  hdmi_pix_feeder #(
    .FIFO_AW(FIFO_AW), .H_ACT(H_ACT), .V_ACT(V_ACT),
    .V_BLANK_LINE(V_BLANK), .FILL_RGB(FILL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sof(s_sof), .hcount(hcount), .vcount(vcount),
    .dat_rdy(dat_rdy), .dat_out(dat_out), .locked(locked),
`ifdef HDMI_PIX_FEEDER_STATS_EN
    .uf_cnt(uf_cnt), .rs_cnt(rs_cnt),
`endif
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents as a queue plus frame-level bookkeeping.
  px_t         mq[$];
  int          m_mode = MS_SYNC;
  int          m_cnt  = 0;
  bit          m_arm  = 0;
  bit          m_uf   = 0;
  bit          m_en   = 0;
  logic [23:0] m_out  = FILL;

  px_t         src[$];
  logic [23:0] got[$];
  logic [23:0] exp_q[$];

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    bit flush;
    flush = (m_mode != MS_RUN) && (mq.size() > 0) && !mq[0].sof;
    return m_en && ((mq.size() < DEPTH) || flush);
  endfunction

  task automatic model_step(input bit rst, input bit v, input logic [23:0] d, input bit sof,
                            input int vc, input bit rdy, output bit acc);
    bit          pop, arm_set, hs;
    logic [23:0] hr;
    int          n;
    acc = 1'b0;
    if (!rst) begin
      mq.delete();
      m_mode = MS_SYNC; m_cnt = 0; m_arm = 0; m_uf = 0; m_en = 0; m_out = FILL;
      return;
    end
    acc     = v && m_ready();
    n       = mq.size();
    hs      = (n > 0) ? mq[0].sof : 1'b0;
    hr      = (n > 0) ? mq[0].rgb : 24'h0;
    pop     = 1'b0;
    arm_set = (vc == V_BLANK) && !rdy;
    if (m_mode == MS_RUN) begin
      if (rdy) begin
        if (n == 0) begin
          m_out = FILL; m_uf = 1; m_mode = MS_RESYNC; m_cnt = 0;
        end else if (hs && m_cnt != 0) begin
          m_out = FILL; m_mode = MS_RESYNC; m_cnt = 0;
        end else if (!hs && m_cnt == 0) begin
          pop = 1; m_out = FILL; m_mode = MS_RESYNC;
        end else begin
          pop = 1; m_out = hr; m_cnt = (m_cnt + 1) % FRAME;
        end
      end
    end else begin
      if (n > 0 && !hs) pop = 1;
      if (rdy) m_out = FILL;
      if (m_mode == MS_SYNC && rdy && n > 0 && hs && m_arm) begin
        pop = 1; m_out = hr; m_cnt = 1 % FRAME; m_mode = MS_RUN;
      end else if (m_mode == MS_RESYNC && arm_set) begin
        m_mode = MS_SYNC;
      end
    end
    if (arm_set) m_arm = 1;
    else if (rdy) m_arm = 0;
    m_en = 1;
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back({sof, d});
  endtask

  task automatic cyc(input bit rst, input bit v, input logic [23:0] d, input bit sof,
                     input int vc, input bit rdy, output bit acc);
    rst_n   = rst;
    s_valid = v;
    s_data  = d;
    s_sof   = sof;
    vcount  = VW'(vc);
    hcount  = HW'($urandom);
    dat_rdy = rdy;
    model_step(rst, v, d, sof, vc, rdy, acc);
    @(posedge clk);
    #1;
    chk("dat_out", dat_out, m_out);
    chk("s_ready", 24'(s_ready), 24'(m_ready()));
    chk("locked", 24'(locked), 24'(m_mode == MS_RUN));
    chk("underflow", 24'(underflow), 24'(m_uf));
    if (rst && rdy) got.push_back(dat_out);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(1, 0, 24'h0, 0, 1, 0, acc);
  endtask

  task automatic do_reset(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(0, 1, 24'hABCDEF, 1, 1, 0, acc);
  endtask

  task automatic arm_pulse();
    bit acc;
    cyc(1, 0, 24'h0, 0, V_BLANK, 0, acc);
  endtask

  task automatic add_frame(input logic [23:0] base, input int n, input int sof_at);
    for (int i = 0; i < n; i++) src.push_back({(i == sof_at), base + 24'(i)});
  endtask

  // Push queued pixels with random gaps until drained or the FIFO stops accepting.
  task automatic feed();
    bit acc, v;
    for (int k = 0; k < 200; k++) begin
      if (src.size() == 0 || !m_ready()) break;
      v = ($urandom_range(0, 3) != 0);
      cyc(1, v, src[0].rgb, src[0].sof, 1, 0, acc);
      if (acc) void'(src.pop_front());
    end
  endtask

  task automatic stream(input int n_req, input bit need_data);
    bit acc, v, rdy;
    int left = n_req;
    got.delete();
    for (int k = 0; k < 400 && left > 0; k++) begin
      v   = (src.size() > 0) && ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0) && (!need_data || mq.size() > 0);
      cyc(1, v, (src.size() > 0) ? src[0].rgb : 24'h0, (src.size() > 0) ? src[0].sof : 1'b0,
          1, rdy, acc);
      if (acc) void'(src.pop_front());
      if (rdy) left--;
    end
    chk("stream_budget_left", 24'(left), 24'd0);
  endtask

  task automatic check_got(input string tag);
    chk({tag, "_len"}, 24'(got.size()), 24'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(tag, got[i], exp_q[i]);
  endtask

  initial begin
    rst_n = 0; s_valid = 0; s_data = '0; s_sof = 0; hcount = '0; vcount = VW'(1); dat_rdy = 0;

    // Reset held 3 clocks with s_valid asserted.
    do_reset(3);
    chk("rst_dat_out", dat_out, 24'h0000FF);
    chk("rst_s_ready", 24'(s_ready), 24'd0);
    chk("rst_locked", 24'(locked), 24'd0);
    chk("rst_underflow", 24'(underflow), 24'd0);
    idle(1);
    chk("rel_s_ready", 24'(s_ready), 24'd1);

    // Nominal frames.
    add_frame(24'h000001, 8, 0);
    feed(); arm_pulse(); stream(8, 1);
    exp_q = '{24'h1, 24'h2, 24'h3, 24'h4, 24'h5, 24'h6, 24'h7, 24'h8};
    check_got("nom1");
    chk("nom1_locked", 24'(locked), 24'd1);
    chk("nom1_underflow", 24'(underflow), 24'd0);
    add_frame(24'h000011, 8, 0);
    feed(); stream(8, 1);
    exp_q = '{24'h11, 24'h12, 24'h13, 24'h14, 24'h15, 24'h16, 24'h17, 24'h18};
    check_got("nom2");

    // Underflow: frame of only 5 pixels.
    add_frame(24'h000021, 5, 0);
    feed(); stream(8, 0);
    exp_q = '{24'h21, 24'h22, 24'h23, 24'h24, 24'h25, FILL, FILL, FILL};
    check_got("uf");
    chk("uf_underflow", 24'(underflow), 24'd1);
    chk("uf_locked", 24'(locked), 24'd0);
    add_frame(24'h000031, 8, 0);
    feed(); arm_pulse(); stream(8, 1);
    exp_q = '{24'h31, 24'h32, 24'h33, 24'h34, 24'h35, 24'h36, 24'h37, 24'h38};
    check_got("uf_relock");
    chk("uf_relock_locked", 24'(locked), 24'd1);

    // Early sof on pixel 3.
    src.push_back({1'b1, 24'h000041});
    src.push_back({1'b0, 24'h000042});
    add_frame(24'h000043, 6, 0);
    feed(); stream(3, 1);
    exp_q = '{24'h41, 24'h42, FILL};
    check_got("early");
    chk("early_locked", 24'(locked), 24'd0);
    arm_pulse(); stream(6, 1);
    exp_q = '{24'h43, 24'h44, 24'h45, 24'h46, 24'h47, 24'h48};
    check_got("early_relock");

    // Junk before sof after a fresh reset.
    do_reset(2); idle(1);
    add_frame(24'h000051, 3, -1);
    add_frame(24'h000061, 8, 0);
    feed(); idle(3); feed(); arm_pulse(); stream(8, 1);
    exp_q = '{24'h61, 24'h62, 24'h63, 24'h64, 24'h65, 24'h66, 24'h67, 24'h68};
    check_got("junk");

    // Reset one clock after pixel 4 of a frame.
    add_frame(24'h000071, 8, 0);
    feed(); stream(4, 1);
    exp_q = '{24'h71, 24'h72, 24'h73, 24'h74};
    check_got("mid");
    src.delete();
    do_reset(1);
    chk("mid_rst_dat_out", dat_out, 24'h0000FF);
    chk("mid_rst_s_ready", 24'(s_ready), 24'd0);
    chk("mid_rst_locked", 24'(locked), 24'd0);
    chk("mid_rst_underflow", 24'(underflow), 24'd0);
    idle(1);
    add_frame(24'h000081, 8, 0);
    feed(); arm_pulse(); stream(8, 1);
    exp_q = '{24'h81, 24'h82, 24'h83, 24'h84, 24'h85, 24'h86, 24'h87, 24'h88};
    check_got("post_rst");

    // Random-valued frames with random late-request gaps.
    for (int f = 0; f < 3; f++) begin
      exp_q.delete();
      for (int i = 0; i < FRAME; i++) begin
        logic [23:0] r;
        r = 24'($urandom);
        exp_q.push_back(r);
        src.push_back({(i == 0), r});
      end
      feed(); stream(FRAME, 1);
      check_got("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
